// File: rtl/hram_cmd_parser.sv
// hram_cmd_parser: UART frame to HyperRAM command engine; HRAM_CMD_TIMEOUT_EN enables the inter-byte gap timeout.
module hram_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int MEM_TIMEOUT = 4096,
  parameter logic [31:0] SIGNATURE = 32'h01010101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic        wr_req,
  output logic        rd_req,
  input  logic        busy,
  input  logic [31:0] rd_d,
  input  logic        rd_rdy,
  output logic        frame_err,
  output logic        cmd_active
);
  localparam logic [2:0] COLLECT = 3'd0, EXEC = 3'd1, MEM_ISSUE = 3'd2, MEM_WAIT = 3'd3, SEND = 3'd4, TX_HOLD = 3'd5;
  logic [2:0] state, bcnt;
  logic [39:0] frame;
  logic [31:0] reply, rd_latch, count, mcnt, arg;
  logic [7:0] op;
  logic [1:0] tcnt;
  logic is_rd, busy_q, mem_to, gap_to, issue;
  assign op = frame[39:32];
  assign arg = frame[31:0];
  assign mem_to = mcnt == 32'(MEM_TIMEOUT - 1);
  // A request never fires in the same cycle the memory budget runs out
  assign issue = state == MEM_ISSUE && !busy && !mem_to;
  assign wr_req = issue && !is_rd;
  assign rd_req = issue && is_rd;
  assign tx_start = state == SEND && tx_ready;
  assign tx_data = reply[31:24];
  assign cmd_active = state != COLLECT;
`ifdef HRAM_CMD_TIMEOUT_EN
  logic [31:0] gap;
  always_ff @(posedge clk or posedge reset)
    if (reset) gap <= '0;
    else gap <= state != COLLECT || rx_valid || bcnt == 3'd0 || gap_to ? '0 : gap + 32'd1;
  assign gap_to = state == COLLECT && bcnt != 3'd0 && !rx_valid && gap == 32'(TIMEOUT_CYCLES - 1);
`else
  assign gap_to = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= COLLECT;
      bcnt <= '0;
      frame <= '0;
      reply <= '0;
      rd_latch <= '0;
      count <= '0;
      mcnt <= '0;
      tcnt <= '0;
      addr <= '0;
      wr_d <= '0;
      is_rd <= 1'b0;
      busy_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      busy_q <= busy;
      frame_err <= rx_valid && state != COLLECT;
      case (state)
        COLLECT:
          if (rx_valid) begin
            frame <= {frame[31:0], rx_data};
            bcnt <= bcnt == 3'd4 ? 3'd0 : bcnt + 3'd1;
            state <= bcnt == 3'd4 ? EXEC : COLLECT;
          end else if (gap_to) begin
            bcnt <= 3'd0;
            frame_err <= 1'b1;
          end
        EXEC: begin
          mcnt <= '0;
          tcnt <= '0;
          is_rd <= op == 8'h05;
          state <= op == 8'h03 || op == 8'h05 ? MEM_ISSUE : SEND;
          case (op)
            8'h01: begin addr <= arg; reply <= arg; end
            8'h02: begin wr_d <= arg; reply <= arg; end
            8'h04: reply <= rd_latch;
            8'h06: begin reply <= count; count <= count + 32'd1; end
            8'h07: reply <= SIGNATURE;
            8'h03, 8'h05: ;
            default: begin reply <= 32'hFFFFFFFF; frame_err <= 1'b1; end
          endcase
        end
        MEM_ISSUE: begin
          mcnt <= mcnt + 32'd1;
          if (mem_to) begin
            reply <= 32'hDEADDEAD;
            frame_err <= 1'b1;
            state <= SEND;
          end else if (!busy) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          mcnt <= mcnt + 32'd1;
          if (is_rd && rd_rdy) begin
            rd_latch <= rd_d;
            reply <= rd_d;
            state <= SEND;
          end else if (!is_rd && busy_q && !busy) begin
            reply <= 32'h00000003;
            state <= SEND;
          end else if (mem_to) begin
            reply <= 32'hDEADDEAD;
            frame_err <= 1'b1;
            state <= SEND;
          end
        end
        SEND:
          if (tx_ready) begin
            reply <= {reply[23:0], 8'h00};
            tcnt <= tcnt + 2'd1;
            state <= tcnt == 2'd3 ? COLLECT : TX_HOLD;
          end
        TX_HOLD: if (!tx_ready) state <= SEND;
        default: state <= COLLECT;
      endcase
    end
endmodule

// File: tb/tb_hram_cmd_parser.sv
// tb_hram_cmd_parser: directed frames checked against a reply-queue model of the command set.
module tb_hram_cmd_parser;
  localparam int TO = 200;
  logic clk, reset, rx_valid, tx_start, tx_ready, wr_req, rd_req, busy, rd_rdy, frame_err, cmd_active;
  logic [7:0] rx_data, tx_data;
  logic [31:0] addr, wr_d, rd_d;
  int tests, fails, tx_seen, wr_cnt, rd_cnt, ferr_cnt, exp_ferr;
  logic [7:0] exp_q[$];
  logic [31:0] m_count, m_latch, m_rdval;
  logic m_memto, wr_prev, rd_prev, tx_prev;

  hram_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .addr(addr), .wr_d(wr_d), .wr_req(wr_req), .rd_req(rd_req),
    .busy(busy), .rd_d(rd_d), .rd_rdy(rd_rdy),
    .frame_err(frame_err), .cmd_active(cmd_active)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Reply the host must see for a frame, from the command table alone
  task automatic model_step(input logic [7:0] op, input logic [31:0] arg);
    logic [31:0] r;
    case (op)
      8'h01, 8'h02: r = arg;
      8'h03: begin r = m_memto ? 32'hDEADDEAD : 32'h3; if (m_memto) exp_ferr++; end
      8'h04: r = m_latch;
      8'h05: begin r = m_rdval; m_latch = m_rdval; end
      8'h06: begin r = m_count; m_count = m_count + 1; end
      8'h07: r = 32'h01010101;
      default: begin r = 32'hFFFFFFFF; exp_ferr++; end
    endcase
    for (int i = 3; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick;
    rx_valid = 0;
    tick;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] arg);
    model_step(op, arg);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(arg[i*8 +: 8]);
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((exp_q.size() != 0 || cmd_active) && n < 10000) begin
      tick;
      n++;
    end
    tests++;
    if (n >= 10000) begin
      fails++;
      $display("FAIL idle timeout: %0d reply bytes still pending", exp_q.size());
    end
  endtask

  // Transmitter: busy for two cycles after each accepted byte
  initial begin
    tx_ready = 1;
    forever begin
      @(negedge clk);
      #3;
      if (tx_start) begin
        @(posedge clk);
        #1 tx_ready = 0;
        repeat (2) @(posedge clk);
        #1 tx_ready = 1;
      end
    end
  end

  initial begin
    wr_prev = 0; rd_prev = 0; tx_prev = 0;
    forever begin
      @(negedge clk);
      #3;
      if (wr_req) begin wr_cnt++; check("wr_req width", {31'd0, wr_prev}, 0); end
      if (rd_req) begin rd_cnt++; check("rd_req width", {31'd0, rd_prev}, 0); end
      if (frame_err) ferr_cnt++;
      if (tx_start) begin
        tx_seen++;
        check("tx_start spacing", {31'd0, tx_prev}, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected tx_start: byte %h, none expected", tx_data);
        end else check("tx byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      wr_prev = wr_req; rd_prev = rd_req; tx_prev = tx_start;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ts, w0;
    tests = 0; fails = 0; tx_seen = 0; wr_cnt = 0; rd_cnt = 0; ferr_cnt = 0; exp_ferr = 0;
    m_count = 0; m_latch = 0; m_rdval = 0; m_memto = 0;
    reset = 1; rx_valid = 0; rx_data = 0; busy = 0; rd_d = 0; rd_rdy = 0;
    repeat (2) tick;
    check("reset strobes", {27'd0, tx_start, wr_req, rd_req, frame_err, cmd_active}, 0);
    check("reset addr", addr, 0);
    check("reset wr_d/tx_data", wr_d | {24'd0, tx_data}, 0);
    reset = 0;
    tick;

    send_frame(8'h01, 32'h12345678);
    check("addr at N+2", addr, 32'h12345678);
    check("first tx at N+2", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'h12});
    wait_idle;

    send_frame(8'h02, 32'hCAFEBABE);
    wait_idle;
    w0 = wr_cnt;
    ts = tx_seen;
    send_frame(8'h03, 32'h0);
    check("wr_req at N+2", {31'd0, wr_req}, 1);
    check("wr_d", wr_d, 32'hCAFEBABE);
    repeat (3) tick;
    busy = 1;
    repeat (4) tick;
    check("no reply before busy falls", tx_seen, ts);
    busy = 0;
    wait_idle;
    check("one wr_req", wr_cnt, w0 + 1);

    m_rdval = 32'hA5A55A5A;
    send_frame(8'h05, 32'h0);
    check("rd_req at N+2", {31'd0, rd_req}, 1);
    repeat (10) tick;
    rd_d = 32'hA5A55A5A;
    rd_rdy = 1;
    tick;
    rd_rdy = 0;
    rd_d = 32'h11111111;
    check("read reply 1 cycle after rd_rdy", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hA5});
    wait_idle;
    rd_rdy = 1;
    repeat (2) tick;
    rd_rdy = 0;
    send_frame(8'h04, 32'h0);
    wait_idle;
    check("rd_req count", rd_cnt, 1);

    busy = 1;
    m_memto = 1;
    w0 = wr_cnt;
    send_frame(8'h03, 32'h0);
    check("no wr_req while busy", {31'd0, wr_req}, 0);
    wait_idle;
    repeat (900) tick;
    busy = 0;
    m_memto = 0;
    repeat (5) tick;
    check("mem timeout no wr_req", wr_cnt, w0);
    check("mem timeout frame_err", ferr_cnt, exp_ferr);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h06, 32'h0);
      wait_idle;
    end
    send_frame(8'h99, 32'h0);
    wait_idle;
    check("bad opcode frame_err", ferr_cnt, exp_ferr);

    send_frame(8'h07, 32'h0);
    tick;
    rx_data = 8'h55;
    rx_valid = 1;
    exp_ferr++;
    tick;
    rx_valid = 0;
    wait_idle;
    send_frame(8'h01, 32'h00000042);
    check("frame after overrun", addr, 32'h00000042);
    wait_idle;
    check("overrun frame_err", ferr_cnt, exp_ferr);

`ifdef HRAM_CMD_TIMEOUT_EN
    send_byte(8'h07);
    send_byte(8'h00);
    repeat (TO + 10) tick;
    exp_ferr++;
    check("gap timeout frame_err", ferr_cnt, exp_ferr);
    send_frame(8'h07, 32'h0);
    wait_idle;
`else
    model_step(8'h07, 32'h0);
    send_byte(8'h07);
    send_byte(8'h00);
    repeat (TO + 10) tick;
    check("partial frame held", {31'd0, cmd_active}, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    wait_idle;
`endif

    send_frame(8'h01, 32'hDEADBEEF);
    tick;
    reset = 1;
    tick;
    check("mid-send reset strobes", {27'd0, tx_start, wr_req, rd_req, frame_err, cmd_active}, 0);
    check("mid-send reset addr", addr, 0);
    check("mid-send reset tx_data", {24'd0, tx_data}, 0);
    exp_q.delete();
    m_count = 0;
    m_latch = 0;
    reset = 0;
    ts = tx_seen;
    repeat (20) tick;
    check("no tx after reset", tx_seen, ts);
    send_frame(8'h06, 32'h0);
    wait_idle;
    send_frame(8'h04, 32'h0);
    wait_idle;

    check("frame_err total", ferr_cnt, exp_ferr);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
